// File: rtl/divider_bank.sv
// divider_bank: NUM_CH programmable dividers, each producing a one-cycle tick and a 50%-duty clock.
// Define DIVBANK_SYNC_EN to add the global phase-align input `sync`.
module divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int CH_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
`ifdef DIVBANK_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [NUM_CH-1:0] wr_sel;
  logic              sync_hit;

`ifdef DIVBANK_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // Decode the write target; an out-of-range wr_ch matches no channel and is dropped.
  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && (int'(wr_ch) == c)) begin
        wr_sel[c] = 1'b1;
      end else begin
        wr_sel[c] = 1'b0;
      end
    end
  end

  // Per-channel period, counter, tick and divided clock; priority rst > sync > write > count.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        period[c]  <= CNT_W'(DEFAULT_DIV);
        cnt[c]     <= '0;
        tick[c]    <= 1'b0;
        clk_out[c] <= 1'b0;
      end else if (sync_hit) begin
        if (wr_sel[c]) begin
          period[c] <= wr_data;
        end else begin
          period[c] <= period[c];
        end
        cnt[c]     <= '0;
        tick[c]    <= 1'b0;
        clk_out[c] <= 1'b0;
      end else if (wr_sel[c]) begin
        // A write on the terminal-count cycle suppresses that tick and toggle.
        period[c] <= wr_data;
        cnt[c]    <= '0;
        tick[c]   <= 1'b0;
      end else if (period[c] == '0) begin
        cnt[c]  <= '0;
        tick[c] <= 1'b0;
      end else if (!en[c]) begin
        tick[c] <= 1'b0;
      end else if (cnt[c] == (period[c] - CNT_W'(1))) begin
        cnt[c]     <= '0;
        tick[c]    <= 1'b1;
        clk_out[c] <= ~clk_out[c];
      end else begin
        cnt[c]  <= cnt[c] + CNT_W'(1);
        tick[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_bank.sv
// Self-checking bench for divider_bank: directed scenarios plus random traffic against
// a phase-counting reference model (tick whenever enabled-cycle count is a multiple of P).
module tb_divider_bank;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 5;
  localparam int CH_W        = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_data;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  int checks   = 0;
  int failures = 0;

  int                m_p     [NUM_CH];
  int                m_phase [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_clk;

  always #5 clk = ~clk;

  divider_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .CH_W(CH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_data(wr_data),
`ifdef DIVBANK_SYNC_EN
    .sync(sync),
`endif
    .tick(tick),
    .clk_out(clk_out)
  );

  // Reference: count enabled cycles since the last restart; a tick lands on every multiple of P.
  task automatic model_edge();
    logic s_now;
`ifdef DIVBANK_SYNC_EN
    s_now = sync;
`else
    s_now = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      logic hit;
      hit = wr_en && (int'(wr_ch) == c);
      if (rst) begin
        m_p[c] = DEFAULT_DIV; m_phase[c] = 0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
      end else if (s_now) begin
        if (hit) m_p[c] = int'(wr_data);
        m_phase[c] = 0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
      end else if (hit) begin
        m_p[c] = int'(wr_data); m_phase[c] = 0; m_tick[c] = 1'b0;
      end else if (m_p[c] == 0 || !en[c]) begin
        m_tick[c] = 1'b0;
      end else begin
        m_phase[c] = m_phase[c] + 1;
        m_tick[c]  = ((m_phase[c] % m_p[c]) == 0);
        if (m_tick[c]) m_clk[c] = ~m_clk[c];
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic [NUM_CH-1:0] e, input logic w,
                      input int ch, input int d, input logic s, input string tag);
    rst = r; en = e; wr_en = w; wr_ch = CH_W'(ch); wr_data = CNT_W'(d); sync = s;
    @(posedge clk);
    model_edge();
    #1;
    check_val({tag, "_tick"}, tick, m_tick);
    check_val({tag, "_clk"}, clk_out, m_clk);
  endtask

  task automatic idle(input int n, input logic [NUM_CH-1:0] e, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, 0, 1'b0, tag);
  endtask

  initial begin
    logic [NUM_CH-1:0] all_on;
    all_on = {NUM_CH{1'b1}};
    rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0; sync = 1'b0;

    // Reset defaults: ticks after edges 5, 10, 15; clk_out 1 after 5, 0 after 10
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "reset");
    check_val("reset_tick0", tick, 4'b0000);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, all_on, 1'b0, 0, 0, 1'b0, "dflt");
      if (i == 5)  check_val("dflt_e5_clk", clk_out, 4'b1111);
      if (i == 10) check_val("dflt_e10_clk", clk_out, 4'b0000);
      if (i == 15) check_val("dflt_e15_tick", tick, 4'b1111);
    end

    // Period write mid-count: P=3 on ch2 at edge 7
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst2");
    for (int i = 1; i <= 15; i++) begin
      if (i == 7) step(1'b0, all_on, 1'b1, 2, 3, 1'b0, "wr_mid");
      else        step(1'b0, all_on, 1'b0, 0, 0, 1'b0, "wr_mid");
      if (i == 10) check_val("wr_mid_e10", tick, 4'b1111);
      if (i == 13) check_val("wr_mid_e13", tick, 4'b0100);
    end

    // P=1 on every channel: constant tick, clk_out toggling
    for (int c = 0; c < NUM_CH; c++) step(1'b0, all_on, 1'b1, c, 1, 1'b0, "p1_wr");
    idle(8, all_on, "p1_run");
    check_val("p1_tick", tick, 4'b1111);

    // P=0 on ch0: halted for 20 cycles, clk_out frozen
    step(1'b0, all_on, 1'b1, 0, 0, 1'b0, "p0_wr");
    idle(20, all_on, "p0_run");

    // Out-of-range write (wr_ch=5) is ignored
    step(1'b0, all_on, 1'b1, 5, 2, 1'b0, "oor_wr");
    idle(6, all_on, "oor_run");

    // Drop en[1] for 3 cycles at cnt=2: its tick moves from edge 5 to edge 8
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst_en");
    for (int i = 1; i <= 12; i++) begin
      if (i >= 3 && i <= 5) step(1'b0, 4'b1101, 1'b0, 0, 0, 1'b0, "en_drop");
      else                  step(1'b0, all_on, 1'b0, 0, 0, 1'b0, "en_drop");
      if (i == 8) check_val("en_drop_e8", tick, 4'b0010);
    end

    // Write on the terminal-count cycle of ch0: write wins, no tick, no toggle
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst_col");
    idle(4, all_on, "col_pre");
    step(1'b0, all_on, 1'b1, 0, 5, 1'b0, "col");
    check_val("col_tick", tick, 4'b1110);
    check_val("col_clk", clk_out, 4'b1110);
    idle(5, all_on, "col_post");

    // Reset at edge 12 overrides a simultaneous write
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst_mid0");
    idle(11, all_on, "mid_pre");
    step(1'b1, all_on, 1'b1, 0, 2, 1'b0, "rst_mid");
    check_val("rst_mid_tick", tick, 4'b0000);
    check_val("rst_mid_clk", clk_out, 4'b0000);
    idle(5, all_on, "mid_post");
    check_val("rst_mid_p_default", tick, 4'b1111);

`ifdef DIVBANK_SYNC_EN
    // Channels at different phases with P=4, sync at edge 9
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst_sync");
    for (int i = 1; i <= 13; i++) begin
      if (i <= 4)      step(1'b0, all_on, 1'b1, i - 1, 4, 1'b0, "sync_wr");
      else if (i == 9) step(1'b0, all_on, 1'b0, 0, 0, 1'b1, "sync_hit");
      else             step(1'b0, all_on, 1'b0, 0, 0, 1'b0, "sync_run");
      if (i == 9)  check_val("sync_clk0", clk_out, 4'b0000);
      if (i == 13) check_val("sync_align", tick, 4'b1111);
    end
`endif

    // Random traffic against the reference model
    step(1'b1, all_on, 1'b0, 0, 0, 1'b0, "rst_rand");
    for (int i = 0; i < 400; i++) begin
      logic r, w, s;
      r = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 4) == 0);
`ifdef DIVBANK_SYNC_EN
      s = ($urandom_range(0, 39) == 0);
`else
      s = 1'b0;
`endif
      step(r, NUM_CH'($urandom_range(0, 15) | ($urandom_range(0, 1) == 1 ? 15 : 0)), w,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), s, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
